// File: rtl/decode_if.sv
// Fetch-to-decode handshake: fetched instruction bundle forward, stall back.
interface decode_if #(
    parameter int INSTR_W = 16,
    parameter int DATA_W  = 16
);
    logic               valid_if;
    logic [INSTR_W-1:0] instruction_if;
    logic [DATA_W-1:0]  next_program_counter_if;
    logic               branch_prediction_bp;
    logic               stall_id;

    modport master (
        output valid_if,
        output instruction_if,
        output next_program_counter_if,
        output branch_prediction_bp,
        input  stall_id
    );

    modport slave (
        input  valid_if,
        input  instruction_if,
        input  next_program_counter_if,
        input  branch_prediction_bp,
        output stall_id
    );
endinterface

// File: rtl/decode_stage.sv
// Instruction decode stage with ID/EX register, writeback bypass and stall/flush.
// Load-use bubble insertion is enabled by defining DECODE_HAZARD_EN.
module decode_stage #(
    parameter int              INSTR_W   = 16,
    parameter int              DATA_W    = 16,
    parameter int              OPC_W     = 4,
    parameter int              REG_IDX_W = 5,
    parameter int              IMM_W     = 7,
    parameter int              TGT_W     = 12,
    parameter logic [OPC_W-1:0] LOAD_OPC = 4'b1000,
    parameter logic [OPC_W-1:0] NOP_OPC  = 4'b0000
) (
    input  logic                 clk,
    input  logic                 rst,
    decode_if.slave              fetch,
    input  logic                 flush_ex,
    input  logic                 stall_ex,
    output logic [REG_IDX_W-1:0] reg1_index_rf,
    output logic [REG_IDX_W-1:0] reg2_index_rf,
    input  logic [DATA_W-1:0]    reg1_data_rf,
    input  logic [DATA_W-1:0]    reg2_data_rf,
    input  logic                 wb_we,
    input  logic [REG_IDX_W-1:0] wb_index,
    input  logic [DATA_W-1:0]    wb_data,
    output logic [OPC_W-1:0]     opcode_id,
    output logic [DATA_W-1:0]    target_address_id,
    output logic                 valid_id,
    output logic [OPC_W-1:0]     control_id,
    output logic [DATA_W-1:0]    next_program_counter_id,
    output logic [DATA_W-1:0]    reg1_data_id,
    output logic [DATA_W-1:0]    reg2_data_id,
    output logic [IMM_W-1:0]     immediate_id,
    output logic [REG_IDX_W-1:0] dest_reg_index_id
);

`ifdef DECODE_HAZARD_EN
    localparam logic HAZARD_EN = 1'b1;
`else
    localparam logic HAZARD_EN = 1'b0;
`endif

    logic [INSTR_W-1:0]   instr;
    logic [OPC_W-1:0]     opc;
    logic [REG_IDX_W-1:0] rs1;
    logic [REG_IDX_W-1:0] rs2;
    logic [IMM_W-1:0]     imm;
    logic                 live;
    logic [DATA_W-1:0]    op1;
    logic [DATA_W-1:0]    op2;
    logic                 load_use;
    logic                 hazard;

    assign instr = fetch.instruction_if;
    assign opc   = instr[INSTR_W-1 -: OPC_W];
    assign rs1   = instr[2*REG_IDX_W-1:REG_IDX_W];
    assign rs2   = instr[REG_IDX_W-1:0];
    assign imm   = instr[REG_IDX_W+IMM_W-1:REG_IDX_W];

    assign reg1_index_rf     = rs1;
    assign reg2_index_rf     = rs2;
    assign target_address_id = DATA_W'(instr[TGT_W-1:0]);

    // Squashed or killed instructions decode as a bubble.
    assign live      = fetch.valid_if & ~fetch.branch_prediction_bp & ~flush_ex;
    assign opcode_id = live ? opc : NOP_OPC;

    assign op1 = (wb_we && wb_index == rs1) ? wb_data : reg1_data_rf;
    assign op2 = (wb_we && wb_index == rs2) ? wb_data : reg2_data_rf;

    assign load_use = valid_id & (control_id == LOAD_OPC) & fetch.valid_if
                    & ((dest_reg_index_id == rs1) | (dest_reg_index_id == rs2));
    assign hazard   = HAZARD_EN & load_use;

    assign fetch.stall_id = stall_ex | (hazard & ~flush_ex);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_id                <= 1'b0;
            control_id              <= NOP_OPC;
            next_program_counter_id <= '0;
            reg1_data_id            <= '0;
            reg2_data_id            <= '0;
            immediate_id            <= '0;
            dest_reg_index_id       <= '0;
        end else if (flush_ex || !stall_ex) begin
            next_program_counter_id <= fetch.next_program_counter_if;
            reg1_data_id            <= op1;
            reg2_data_id            <= op2;
            immediate_id            <= imm;
            dest_reg_index_id       <= rs2;
            if (flush_ex || hazard) begin
                valid_id   <= 1'b0;
                control_id <= NOP_OPC;
            end else begin
                valid_id   <= fetch.valid_if & ~fetch.branch_prediction_bp;
                control_id <= (fetch.valid_if & ~fetch.branch_prediction_bp)
                              ? opc : NOP_OPC;
            end
        end
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised instruction-decode pipeline stage. It sits between fetch and execute: it extracts opcode, register indices, immediate and jump target from the fetched word, and reads both register-file ports combinationally. It latches everything into the ID/EX pipeline register. Unlike the first-generation decode stage, it carries a valid bit, honours downstream stall and flush, and bypasses same-cycle register writeback. It also detects load-use hazards and inserts a bubble while back-pressuring fetch.

## Interface
Parameters:
- INSTR_W, 16, instruction width
- DATA_W, 16, register/PC data width
- OPC_W, 4, opcode field width, taken from instr[INSTR_W-1 -: OPC_W]
- REG_IDX_W, 5, register index width
- IMM_W, 7, immediate field width
- TGT_W, 12, jump-target field width, taken from instr[TGT_W-1:0]
- LOAD_OPC, 4'b1000, opcode treated as a load for hazard detection
- NOP_OPC, 4'b0000, control value of a bubble

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset; synchronous, active-high
- valid_if  in  1  fetch presents an instruction
- instruction_if  in  INSTR_W  fetched instruction
- next_program_counter_if  in  DATA_W  PC+1 of fetched instruction
- branch_prediction_bp  in  1  predicted-taken; squash the presented instruction
- flush_ex  in  1  execute mispredict; kill ID register and presented instruction
- stall_ex  in  1  execute cannot accept; hold ID register
- reg1_index_rf, reg2_index_rf  out  REG_IDX_W  combinational read indices
- reg1_data_rf, reg2_data_rf  in  DATA_W  combinational read data
- wb_we, wb_index, wb_data  in  1/REG_IDX_W/DATA_W  writeback port, used for bypass
- stall_id  out  1  fetch must hold its current instruction
- opcode_id  out  OPC_W  combinational decoded opcode (NOP_OPC when squashed)
- target_address_id  out  DATA_W  instr[TGT_W-1:0], zero-extended, combinational
- valid_id, control_id, next_program_counter_id, reg1_data_id, reg2_data_id, immediate_id, dest_reg_index_id  out  registered ID/EX fields (widths 1, OPC_W, DATA_W, DATA_W, DATA_W, IMM_W, REG_IDX_W)

## Operation
- Field map:
  - rs1 = instr[2*REG_IDX_W-1:REG_IDX_W]
  - rs2 = dest = instr[REG_IDX_W-1:0]
  - imm = instr[REG_IDX_W+IMM_W-1:REG_IDX_W]
- Bypass: if wb_we and wb_index equals a read index, use wb_data for that operand instead of rf data. Index 0 is bypassed like any other.
- Hazard (macro-dependent):
  - hazard = valid_id & (control_id==LOAD_OPC) & valid_if & (dest_reg_index_id==rs1 | dest_reg_index_id==rs2)
- stall_id = stall_ex | (hazard & ~flush_ex).
- Per-cycle priority at posedge:
  1. rst: all registered outputs 0; control_id=NOP_OPC.
  2. flush_ex: valid_id=0, control_id=NOP_OPC; other fields don't-care but must be deterministic (capture normally).
  3. stall_ex: every ID register holds.
  4. hazard: bubble; valid_id=0, control_id=NOP_OPC; fetch holds, so the same instruction re-presents next cycle.
  5. Else capture: valid_id = valid_if & ~branch_prediction_bp; control_id = opcode if valid, else NOP_OPC; data fields captured.
- A squashed or invalid instruction never asserts hazard on a later cycle, because valid_id is 0.

## Timing
- Latency: 1 cycle, presentation to ID register.
- stall_id is combinational from the current-cycle inputs and registers.
- A load-use pair costs exactly one bubble cycle.
- After rst deasserts, the first capture occurs on the next posedge with valid_if=1.
- Reset applied mid-stall clears state; stall_id falls in the same cycle that rst is sampled, since valid_id is already 0 after the edge.
- Simultaneous flush_ex and stall_ex: flush wins.
- Simultaneous hazard and branch_prediction_bp: hazard wins; the prediction is re-applied on re-presentation.

## Configuration
- DECODE_HAZARD_EN defined: load-use detection and bubble insertion active as above.
- DECODE_HAZARD_EN undefined: hazard is constant 0 and stall_id = stall_ex; the compiler software must schedule load delay slots.

## Test plan
- Reset: rst=1 for 2 cycles with random inputs -> all ID outputs 0, control_id=0000, stall_id=stall_ex.
- Plain capture: instr 16'h1234, pc 16'h0011, rf data 16'hAAAA/16'h5555 -> next cycle control_id=1, immediate_id=7'h11, dest=5'h14, reg1_index_rf=5'h11, valid_id=1; target_address_id=16'h0234 combinationally.
- Bypass: wb_we=1, wb_index=rs1, wb_data=16'hBEEF, rf data 16'h0000 -> reg1_data_id=16'hBEEF.
- Load-use: load writing r3 followed by an instruction with rs2=3 -> stall_id=1 for one cycle, one bubble (valid_id=0), then the dependent instruction is captured. With DECODE_HAZARD_EN undefined, no bubble occurs.
- Stall then flush: stall_ex=1 for 3 cycles -> ID outputs stable; flush_ex=1 together with stall_ex -> valid_id=0, control_id=0000 next cycle.
- Branch squash: branch_prediction_bp=1 with instr 16'h5ABC -> opcode_id=0000, next cycle valid_id=0.
